// File: rtl/axi_rd_router.sv
// Read-channel router: steers the granted master's AR to the slave, returns R.
// Optional beat-count checking is enabled by defining AXI_RD_BEAT_CHECK_EN.
module axi_rd_router #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              m0_rgrnt,
    input  logic              m1_rgrnt,
    input  logic              m2_rgrnt,
    input  logic              m3_rgrnt,
    input  logic [ID_W-1:0]   m0_ARID,
    input  logic [ADDR_W-1:0] m0_ARADDR,
    input  logic [7:0]        m0_ARLEN,
    input  logic [2:0]        m0_ARSIZE,
    input  logic [1:0]        m0_ARBURST,
    input  logic              m0_ARVALID,
    output logic              m0_ARREADY,
    input  logic [ID_W-1:0]   m1_ARID,
    input  logic [ADDR_W-1:0] m1_ARADDR,
    input  logic [7:0]        m1_ARLEN,
    input  logic [2:0]        m1_ARSIZE,
    input  logic [1:0]        m1_ARBURST,
    input  logic              m1_ARVALID,
    output logic              m1_ARREADY,
    input  logic [ID_W-1:0]   m2_ARID,
    input  logic [ADDR_W-1:0] m2_ARADDR,
    input  logic [7:0]        m2_ARLEN,
    input  logic [2:0]        m2_ARSIZE,
    input  logic [1:0]        m2_ARBURST,
    input  logic              m2_ARVALID,
    output logic              m2_ARREADY,
    input  logic [ID_W-1:0]   m3_ARID,
    input  logic [ADDR_W-1:0] m3_ARADDR,
    input  logic [7:0]        m3_ARLEN,
    input  logic [2:0]        m3_ARSIZE,
    input  logic [1:0]        m3_ARBURST,
    input  logic              m3_ARVALID,
    output logic              m3_ARREADY,
    output logic [ID_W-1:0]   m0_RID,
    output logic [DATA_W-1:0] m0_RDATA,
    output logic [1:0]        m0_RRESP,
    output logic              m0_RLAST,
    output logic              m0_RVALID,
    input  logic              m0_RREADY,
    output logic [ID_W-1:0]   m1_RID,
    output logic [DATA_W-1:0] m1_RDATA,
    output logic [1:0]        m1_RRESP,
    output logic              m1_RLAST,
    output logic              m1_RVALID,
    input  logic              m1_RREADY,
    output logic [ID_W-1:0]   m2_RID,
    output logic [DATA_W-1:0] m2_RDATA,
    output logic [1:0]        m2_RRESP,
    output logic              m2_RLAST,
    output logic              m2_RVALID,
    input  logic              m2_RREADY,
    output logic [ID_W-1:0]   m3_RID,
    output logic [DATA_W-1:0] m3_RDATA,
    output logic [1:0]        m3_RRESP,
    output logic              m3_RLAST,
    output logic              m3_RVALID,
    input  logic              m3_RREADY,
    output logic [ID_W-1:0]   s_ARID,
    output logic [ADDR_W-1:0] s_ARADDR,
    output logic [7:0]        s_ARLEN,
    output logic [2:0]        s_ARSIZE,
    output logic [1:0]        s_ARBURST,
    output logic              s_ARVALID,
    input  logic              s_ARREADY,
    input  logic [ID_W-1:0]   s_RID,
    input  logic [DATA_W-1:0] s_RDATA,
    input  logic [1:0]        s_RRESP,
    input  logic              s_RLAST,
    input  logic              s_RVALID,
    output logic              s_RREADY,
    output logic              rd_busy,
    output logic [1:0]        rd_owner,
    output logic              rd_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0] state;
    logic [1:0] owner;
    logic [1:0] sel;

    logic [3:0] grnt;
    logic [3:0] arvalid;
    logic [3:0] rready;
    logic [3:0] arready;
    logic [3:0] rvalid;
    logic [3:0] rlast;

    logic [ID_W-1:0]   arid    [4];
    logic [ADDR_W-1:0] araddr  [4];
    logic [7:0]        arlen   [4];
    logic [2:0]        arsize  [4];
    logic [1:0]        arburst [4];
    logic [ID_W-1:0]   rid     [4];
    logic [DATA_W-1:0] rdata   [4];
    logic [1:0]        rresp   [4];

    logic in_addr;
    logic in_data;
    logic start;
    logic ar_hs;
    logic r_hs;
    logic last;

    assign grnt    = {m3_rgrnt, m2_rgrnt, m1_rgrnt, m0_rgrnt};
    assign arvalid = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};
    assign rready  = {m3_RREADY, m2_RREADY, m1_RREADY, m0_RREADY};

    assign arid    = '{m0_ARID, m1_ARID, m2_ARID, m3_ARID};
    assign araddr  = '{m0_ARADDR, m1_ARADDR, m2_ARADDR, m3_ARADDR};
    assign arlen   = '{m0_ARLEN, m1_ARLEN, m2_ARLEN, m3_ARLEN};
    assign arsize  = '{m0_ARSIZE, m1_ARSIZE, m2_ARSIZE, m3_ARSIZE};
    assign arburst = '{m0_ARBURST, m1_ARBURST, m2_ARBURST, m3_ARBURST};

    // Lowest-index grant wins if the arbiter ever hands out more than one.
    always_comb begin
        sel = 2'd0;
        if (grnt[0])      sel = 2'd0;
        else if (grnt[1]) sel = 2'd1;
        else if (grnt[2]) sel = 2'd2;
        else if (grnt[3]) sel = 2'd3;
    end

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);
    assign start   = (state == IDLE) && (|grnt) && arvalid[sel];
    assign ar_hs   = s_ARVALID && s_ARREADY;
    assign r_hs    = in_data && s_RVALID && s_RREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
            owner <= 2'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= ADDR;
                    owner <= sel;
                end
                ADDR: if (ar_hs) state <= DATA;
                DATA: if (r_hs && last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_RD_BEAT_CHECK_EN
    logic [7:0] cnt;
    logic [7:0] len;
    logic       len_hit;

    assign len_hit = (cnt == len);
    // A missing RLAST on the final expected beat is synthesised here.
    assign last    = s_RLAST || len_hit;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt    <= 8'd0;
            len    <= 8'd0;
            rd_err <= 1'b0;
        end else begin
            rd_err <= r_hs && (s_RLAST != len_hit);
            if (ar_hs) begin
                len <= arlen[owner];
                cnt <= 8'd0;
            end else if (r_hs) begin
                cnt <= cnt + 8'd1;
            end
        end
    end
`else
    assign last   = s_RLAST;
    assign rd_err = 1'b0;
`endif

    assign s_ARVALID = in_addr && arvalid[owner];
    assign s_ARID    = in_addr ? arid[owner]    : '0;
    assign s_ARADDR  = in_addr ? araddr[owner]  : '0;
    assign s_ARLEN   = in_addr ? arlen[owner]   : '0;
    assign s_ARSIZE  = in_addr ? arsize[owner]  : '0;
    assign s_ARBURST = in_addr ? arburst[owner] : '0;
    assign s_RREADY  = in_data && rready[owner];
    assign rd_busy   = (state != IDLE);
    assign rd_owner  = owner;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            arready[i] = in_addr && (owner == 2'(i)) && s_ARREADY;
            rvalid[i]  = in_data && (owner == 2'(i)) && s_RVALID;
            rlast[i]   = in_data && (owner == 2'(i)) && last;
            rid[i]     = (in_data && owner == 2'(i)) ? s_RID   : '0;
            rdata[i]   = (in_data && owner == 2'(i)) ? s_RDATA : '0;
            rresp[i]   = (in_data && owner == 2'(i)) ? s_RRESP : '0;
        end
    end

    assign {m3_ARREADY, m2_ARREADY, m1_ARREADY, m0_ARREADY} = arready;
    assign {m3_RVALID, m2_RVALID, m1_RVALID, m0_RVALID}     = rvalid;
    assign {m3_RLAST, m2_RLAST, m1_RLAST, m0_RLAST}         = rlast;

    assign m0_RID   = rid[0];
    assign m1_RID   = rid[1];
    assign m2_RID   = rid[2];
    assign m3_RID   = rid[3];
    assign m0_RDATA = rdata[0];
    assign m1_RDATA = rdata[1];
    assign m2_RDATA = rdata[2];
    assign m3_RDATA = rdata[3];
    assign m0_RRESP = rresp[0];
    assign m1_RRESP = rresp[1];
    assign m2_RRESP = rresp[2];
    assign m3_RRESP = rresp[3];

endmodule

// File: tb/tb_axi_rd_router.sv
// Directed self-checking bench for axi_rd_router.
// Covers routing, grant locking, R backpressure, async reset and priority.
module tb_axi_rd_router;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  grnt;
    logic [3:0]  arvalid;
    logic [3:0]  rready;
    logic [3:0]  arready;
    logic [3:0]  rvalid;
    logic [3:0]  rlast;
    logic [3:0]  arid   [4];
    logic [31:0] araddr [4];
    logic [7:0]  arlen  [4];
    logic [2:0]  arsize [4];
    logic [1:0]  arburst[4];
    logic [3:0]  rid    [4];
    logic [31:0] rdata  [4];
    logic [1:0]  rresp  [4];

    logic [3:0]  s_ARID;
    logic [31:0] s_ARADDR;
    logic [7:0]  s_ARLEN;
    logic [2:0]  s_ARSIZE;
    logic [1:0]  s_ARBURST;
    logic        s_ARVALID;
    logic        s_ARREADY;
    logic [3:0]  s_RID;
    logic [31:0] s_RDATA;
    logic [1:0]  s_RRESP;
    logic        s_RLAST;
    logic        s_RVALID;
    logic        s_RREADY;
    logic        rd_busy;
    logic [1:0]  rd_owner;
    logic        rd_err;

    int checks = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    axi_rd_router dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m0_rgrnt(grnt[0]), .m1_rgrnt(grnt[1]),
        .m2_rgrnt(grnt[2]), .m3_rgrnt(grnt[3]),
        .m0_ARID(arid[0]), .m0_ARADDR(araddr[0]), .m0_ARLEN(arlen[0]),
        .m0_ARSIZE(arsize[0]), .m0_ARBURST(arburst[0]),
        .m0_ARVALID(arvalid[0]), .m0_ARREADY(arready[0]),
        .m1_ARID(arid[1]), .m1_ARADDR(araddr[1]), .m1_ARLEN(arlen[1]),
        .m1_ARSIZE(arsize[1]), .m1_ARBURST(arburst[1]),
        .m1_ARVALID(arvalid[1]), .m1_ARREADY(arready[1]),
        .m2_ARID(arid[2]), .m2_ARADDR(araddr[2]), .m2_ARLEN(arlen[2]),
        .m2_ARSIZE(arsize[2]), .m2_ARBURST(arburst[2]),
        .m2_ARVALID(arvalid[2]), .m2_ARREADY(arready[2]),
        .m3_ARID(arid[3]), .m3_ARADDR(araddr[3]), .m3_ARLEN(arlen[3]),
        .m3_ARSIZE(arsize[3]), .m3_ARBURST(arburst[3]),
        .m3_ARVALID(arvalid[3]), .m3_ARREADY(arready[3]),
        .m0_RID(rid[0]), .m0_RDATA(rdata[0]), .m0_RRESP(rresp[0]),
        .m0_RLAST(rlast[0]), .m0_RVALID(rvalid[0]), .m0_RREADY(rready[0]),
        .m1_RID(rid[1]), .m1_RDATA(rdata[1]), .m1_RRESP(rresp[1]),
        .m1_RLAST(rlast[1]), .m1_RVALID(rvalid[1]), .m1_RREADY(rready[1]),
        .m2_RID(rid[2]), .m2_RDATA(rdata[2]), .m2_RRESP(rresp[2]),
        .m2_RLAST(rlast[2]), .m2_RVALID(rvalid[2]), .m2_RREADY(rready[2]),
        .m3_RID(rid[3]), .m3_RDATA(rdata[3]), .m3_RRESP(rresp[3]),
        .m3_RLAST(rlast[3]), .m3_RVALID(rvalid[3]), .m3_RREADY(rready[3]),
        .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN),
        .s_ARSIZE(s_ARSIZE), .s_ARBURST(s_ARBURST),
        .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
        .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
        .s_RLAST(s_RLAST), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
        .rd_busy(rd_busy), .rd_owner(rd_owner), .rd_err(rd_err)
    );

    task automatic clear_inputs();
        grnt = 4'b0; arvalid = 4'b0; rready = 4'b0;
        s_ARREADY = 1'b0; s_RVALID = 1'b0; s_RLAST = 1'b0;
        s_RID = 4'h0; s_RDATA = 32'h0; s_RRESP = 2'b00;
        for (int i = 0; i < 4; i++) begin
            arid[i] = 4'h0; araddr[i] = 32'h0; arlen[i] = 8'h0;
            arsize[i] = 3'd0; arburst[i] = 2'd0;
        end
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1;
        checks++; if (rd_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rd_busy); end
        checks++; if (rd_owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", rd_owner); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", rd_err); end
        checks++; if ({s_ARVALID, s_RREADY, arready, rvalid} !== 10'b0) begin failures++; $display("FAIL reset_valids got=%b exp=0", {s_ARVALID, s_RREADY, arready, rvalid}); end
        checks++; if (s_ARADDR !== 32'h0) begin failures++; $display("FAIL reset_araddr got=%h exp=0", s_ARADDR); end
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic test_basic();
        grnt = 4'b0010; arvalid[1] = 1'b1; araddr[1] = 32'h1000;
        arlen[1] = 8'd3; arid[1] = 4'h5; arsize[1] = 3'd2; arburst[1] = 2'd1;
        s_ARREADY = 1'b1;
        #1;
        checks++; if (s_ARVALID !== 1'b0) begin failures++; $display("FAIL basic_idle_arvalid got=%b exp=0", s_ARVALID); end
        @(negedge ACLK);
        checks++; if (s_ARVALID !== 1'b1) begin failures++; $display("FAIL basic_arvalid got=%b exp=1", s_ARVALID); end
        checks++; if (s_ARADDR !== 32'h1000) begin failures++; $display("FAIL basic_araddr got=%h exp=1000", s_ARADDR); end
        checks++; if ({s_ARID, s_ARLEN, s_ARSIZE, s_ARBURST} !== {4'h5, 8'd3, 3'd2, 2'd1}) begin failures++; $display("FAIL basic_arpayload got=%h/%h/%h/%h", s_ARID, s_ARLEN, s_ARSIZE, s_ARBURST); end
        checks++; if (arready !== 4'b0010) begin failures++; $display("FAIL basic_arready got=%b exp=0010", arready); end
        checks++; if (rd_owner !== 2'd1 || rd_busy !== 1'b1) begin failures++; $display("FAIL basic_owner got=%0d busy=%b exp=1/1", rd_owner, rd_busy); end
        @(negedge ACLK);
        grnt = 4'b0; arvalid = 4'b0;
        #1;
        checks++; if (s_ARVALID !== 1'b0 || arready !== 4'b0) begin failures++; $display("FAIL basic_data_ar got=%b/%b exp=0", s_ARVALID, arready); end
        for (int b = 0; b < 4; b++) begin
            s_RVALID = 1'b1; s_RDATA = 32'hA000_0000 + 32'(b);
            s_RLAST = (b == 3); s_RID = 4'h5; s_RRESP = 2'b00; rready = 4'b0010;
            #1;
            checks++; if (rvalid !== 4'b0010) begin failures++; $display("FAIL basic_rvalid beat=%0d got=%b exp=0010", b, rvalid); end
            checks++; if (rdata[1] !== 32'hA000_0000 + 32'(b) || rdata[0] !== 32'h0) begin failures++; $display("FAIL basic_rdata beat=%0d got=%h exp=%h", b, rdata[1], 32'hA000_0000 + 32'(b)); end
            checks++; if (rlast[1] !== (b == 3) || rid[1] !== 4'h5) begin failures++; $display("FAIL basic_rlast beat=%0d got=%b id=%h", b, rlast[1], rid[1]); end
            checks++; if (s_RREADY !== 1'b1) begin failures++; $display("FAIL basic_rready beat=%0d got=%b exp=1", b, s_RREADY); end
            @(negedge ACLK);
        end
        s_RVALID = 1'b0; s_RLAST = 1'b0; rready = 4'b0;
        #1;
        checks++; if (rd_busy !== 1'b0 || rvalid !== 4'b0) begin failures++; $display("FAIL basic_done busy=%b rvalid=%b exp=0", rd_busy, rvalid); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", rd_err); end
    endtask

    task automatic test_grant_lock();
        do_reset();
        grnt = 4'b0001; arvalid[0] = 1'b1; araddr[0] = 32'h2000;
        arlen[0] = 8'd2; s_ARREADY = 1'b0;
        @(negedge ACLK);
        grnt = 4'b0100; arvalid[2] = 1'b1; araddr[2] = 32'h3000;
        #1;
        checks++; if (rd_owner !== 2'd0 || s_ARADDR !== 32'h2000) begin failures++; $display("FAIL lock_addr owner=%0d addr=%h exp=0/2000", rd_owner, s_ARADDR); end
        checks++; if (arready !== 4'b0000) begin failures++; $display("FAIL lock_arready_wait got=%b exp=0000", arready); end
        @(negedge ACLK);
        s_ARREADY = 1'b1;
        #1;
        checks++; if (arready !== 4'b0001) begin failures++; $display("FAIL lock_arready got=%b exp=0001", arready); end
        @(negedge ACLK);
        arvalid[0] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            s_RVALID = 1'b1; s_RDATA = 32'hB000 + 32'(b); s_RLAST = (b == 2);
            rready = 4'b0101;
            #1;
            checks++; if (rvalid !== 4'b0001 || rdata[0] !== 32'hB000 + 32'(b)) begin failures++; $display("FAIL lock_beat=%0d rvalid=%b data=%h", b, rvalid, rdata[0]); end
            checks++; if (arready !== 4'b0 || rd_owner !== 2'd0) begin failures++; $display("FAIL lock_m2 beat=%0d arready=%b owner=%0d", b, arready, rd_owner); end
            @(negedge ACLK);
        end
        s_RVALID = 1'b0; s_RLAST = 1'b0; rready = 4'b0;
        #1;
        checks++; if (rd_busy !== 1'b0 || arready !== 4'b0) begin failures++; $display("FAIL lock_idle busy=%b arready=%b exp=0", rd_busy, arready); end
        @(negedge ACLK);
        checks++; if (rd_owner !== 2'd2 || arready !== 4'b0100 || s_ARADDR !== 32'h3000) begin failures++; $display("FAIL lock_next owner=%0d arready=%b addr=%h", rd_owner, arready, s_ARADDR); end
    endtask

    task automatic test_rready_toggle();
        logic [4:0] pat;
        int idx;
        do_reset();
        pat = 5'b10101;
        idx = 0;
        grnt = 4'b1000; arvalid[3] = 1'b1; arlen[3] = 8'd2; s_ARREADY = 1'b1;
        repeat (2) @(negedge ACLK);
        grnt = 4'b0; arvalid = 4'b0;
        for (int c = 0; c < 5; c++) begin
            s_RVALID = 1'b1; s_RDATA = 32'hC000 + 32'(idx);
            s_RLAST = (idx == 2); rready[3] = pat[4 - c];
            #1;
            checks++; if (s_RREADY !== pat[4 - c]) begin failures++; $display("FAIL toggle_rready c=%0d got=%b exp=%b", c, s_RREADY, pat[4 - c]); end
            checks++; if (rvalid !== 4'b1000 || rdata[3] !== 32'hC000 + 32'(idx)) begin failures++; $display("FAIL toggle_beat c=%0d rvalid=%b data=%h exp=%h", c, rvalid, rdata[3], 32'hC000 + 32'(idx)); end
            if (pat[4 - c]) idx++;
            @(negedge ACLK);
        end
        s_RVALID = 1'b0; s_RLAST = 1'b0; rready = 4'b0;
        #1;
        checks++; if (idx != 3 || rd_busy !== 1'b0) begin failures++; $display("FAIL toggle_count beats=%0d busy=%b exp=3/0", idx, rd_busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        grnt = 4'b0001; arvalid[0] = 1'b1; arlen[0] = 8'd3; s_ARREADY = 1'b1;
        repeat (2) @(negedge ACLK);
        grnt = 4'b0; arvalid = 4'b0;
        s_RVALID = 1'b1; rready = 4'b0001; s_RDATA = 32'hD0;
        @(negedge ACLK);
        s_RDATA = 32'hD1;
        #1;
        checks++; if (rvalid !== 4'b0001) begin failures++; $display("FAIL rstmid_pre rvalid=%b exp=0001", rvalid); end
        ARESETn = 1'b0;
        #1;
        checks++; if ({rd_busy, rd_owner, s_RREADY, rvalid, rdata[0]} !== 40'h0) begin failures++; $display("FAIL rstmid_outs busy=%b rvalid=%b rready=%b data=%h", rd_busy, rvalid, s_RREADY, rdata[0]); end
        clear_inputs();
        @(negedge ACLK);
        ARESETn = 1'b1;
        grnt = 4'b0001; arvalid[0] = 1'b1; araddr[0] = 32'h4000; s_ARREADY = 1'b1;
        @(negedge ACLK);
        checks++; if (s_ARVALID !== 1'b1 || s_ARADDR !== 32'h4000 || rd_owner !== 2'd0) begin failures++; $display("FAIL rstmid_fresh arvalid=%b addr=%h owner=%0d", s_ARVALID, s_ARADDR, rd_owner); end
    endtask

    task automatic test_priority();
        do_reset();
        grnt = 4'b0010; arvalid = 4'b0;
        @(negedge ACLK);
        checks++; if (rd_busy !== 1'b0) begin failures++; $display("FAIL prio_noarvalid busy=%b exp=0", rd_busy); end
        grnt = 4'b0110; arvalid = 4'b0110;
        araddr[1] = 32'h5100; araddr[2] = 32'h5200; s_ARREADY = 1'b1;
        @(negedge ACLK);
        checks++; if (rd_owner !== 2'd1 || arready !== 4'b0010 || s_ARADDR !== 32'h5100) begin failures++; $display("FAIL prio_owner owner=%0d arready=%b addr=%h", rd_owner, arready, s_ARADDR); end
    endtask

`ifdef AXI_RD_BEAT_CHECK_EN
    task automatic test_beat_check();
        do_reset();
        grnt = 4'b0001; arvalid[0] = 1'b1; arlen[0] = 8'd1; s_ARREADY = 1'b1;
        repeat (2) @(negedge ACLK);
        grnt = 4'b0; arvalid = 4'b0;
        s_RVALID = 1'b1; s_RLAST = 1'b0; rready = 4'b0001;
        #1;
        checks++; if (rlast[0] !== 1'b0) begin failures++; $display("FAIL beat_first rlast=%b exp=0", rlast[0]); end
        @(negedge ACLK);
        checks++; if (rlast[0] !== 1'b1 || rd_err !== 1'b0) begin failures++; $display("FAIL beat_forced rlast=%b err=%b exp=1/0", rlast[0], rd_err); end
        @(negedge ACLK);
        s_RVALID = 1'b0; rready = 4'b0;
        checks++; if (rd_err !== 1'b1 || rd_busy !== 1'b0) begin failures++; $display("FAIL beat_err err=%b busy=%b exp=1/0", rd_err, rd_busy); end
        @(negedge ACLK);
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL beat_pulse err=%b exp=0", rd_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_grant_lock();
        test_rready_toggle();
        test_reset_mid();
        test_priority();
`ifdef AXI_RD_BEAT_CHECK_EN
        test_beat_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
